sdram_burst_reader: RTL

Real SDRAM-side read engine that produces the 16x16-bit line consumed by cpu_dmem_acc_wrapper (rd_req / rd_buf / rd_done). It replaces the behavioural SDRAM model in hardware builds.
- On rd_req it issues one burst command to the SDRAM controller.
- It collects BEATS 16-bit read beats into a line buffer.
- It returns the full line with a single-cycle rd_done.
- A watchdog aborts stalled bursts and flags an error.

---
 rtl/sdram_burst_reader_if.sv | 29 ++
 rtl/sdram_burst_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_reader_if.sv
// Bundles the line-request side (towards the wrapper) and the burst side
// (towards the SDRAM controller) of the burst reader.
// slave  = the reader itself, master = whoever drives it (wrapper/controller/bench).
interface sdram_burst_reader_if #(
  parameter int ADDR_W = 24,
  parameter int BEATS  = 16
);
  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic [BEATS-1:0][15:0] rd_buf;
  logic                   rd_done;
  logic                   rd_err;
  logic                   busy;
  logic                   sd_cmd_valid;
  logic                   sd_cmd_ready;
  logic [ADDR_W-1:0]      sd_cmd_addr;
  logic                   sd_rdata_valid;
  logic [15:0]            sd_rdata;

  modport slave (
    input  rd_req, rd_addr, sd_cmd_ready, sd_rdata_valid, sd_rdata,
    output rd_buf, rd_done, rd_err, busy, sd_cmd_valid, sd_cmd_addr
  );

  modport master (
    output rd_req, rd_addr, sd_cmd_ready, sd_rdata_valid, sd_rdata,
    input  rd_buf, rd_done, rd_err, busy, sd_cmd_valid, sd_cmd_addr
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// SDRAM-side line read engine: one burst command per request, BEATS x 16-bit
// beats collected into a line buffer, single-cycle rd_done, watchdog abort.
module sdram_burst_reader #(
  parameter int ADDR_W  = 24,
  parameter int BEATS   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_burst_reader_if.slave bus
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int WD_W   = $clog2(TIMEOUT) + 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  // Clears the in-line word offset so bursts always start on a line boundary.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(BEATS - 1));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
  logic [BEATS-1:0][15:0] rd_buf_q;
  logic                   buf_we;

  // Next-state and output decode; all outputs are registered from these _d values.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wd_d        = wd_q;
    done_d      = 1'b0;
    err_d       = err_q;
    busy_d      = busy_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    buf_we      = 1'b0;

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (bus.rd_req) begin
          cmd_addr_d  = bus.rd_addr & LINE_MASK;
          busy_d      = 1'b1;
          cmd_valid_d = 1'b1;
          wd_d        = {WD_W{1'b0}};
          state_d     = CMD;
        end else begin
          busy_d      = 1'b0;
          cmd_valid_d = 1'b0;
        end
      end

      CMD: begin
        if (bus.sd_cmd_ready) begin
          cmd_valid_d = 1'b0;
          beat_d      = {BEAT_W{1'b0}};
          wd_d        = {WD_W{1'b0}};
          state_d     = COLLECT;
        end else if (wd_q == WD_LAST) begin
          // Controller never took the command: give up and report.
          cmd_valid_d = 1'b0;
          err_d       = 1'b1;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      COLLECT: begin
        if (bus.sd_rdata_valid) begin
          buf_we = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          wd_d   = {WD_W{1'b0}};
          if (beat_q == BEAT_LAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end else if (wd_q == WD_LAST) begin
          // Burst stalled: hand back a partial line flagged as bad.
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        err_d   = 1'b0;
        beat_d  = {BEAT_W{1'b0}};
        wd_d    = {WD_W{1'b0}};
        state_d = IDLE;
      end

      default: begin
        busy_d      = 1'b0;
        err_d       = 1'b0;
        cmd_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Control/state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= {BEAT_W{1'b0}};
      wd_q        <= {WD_W{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wd_q        <= wd_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  // Line buffer: one beat written per strobe in COLLECT, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_buf_q <= {BEATS{16'h0000}};
    end else if (buf_we) begin
      rd_buf_q[beat_q] <= bus.sd_rdata;
    end else begin
      rd_buf_q <= rd_buf_q;
    end
  end

  assign bus.rd_buf       = rd_buf_q;
  assign bus.rd_done      = done_q;
  assign bus.rd_err       = err_q;
  assign bus.busy         = busy_q;
  assign bus.sd_cmd_valid = cmd_valid_q;
  assign bus.sd_cmd_addr  = cmd_addr_q;
endmodule
